// File: rtl/mt_untemper_if.sv
// Word handshake between an MT19937 generator and its capture side.
// master drives valid/data and reads start; slave is the reverse.
interface mt_untemper_if;
    logic        valid;
    logic [31:0] data;
    logic        start;

    modport master (
        output valid,
        output data,
        input  start
    );

    modport slave (
        input  valid,
        input  data,
        output start
    );
endinterface

// File: rtl/mt_untemper.sv
// Inverse MT19937 tempering: captures 624 tempered words over the rng
// handshake, untempers each and stores the recovered state in a RAM.
// Ports: clk, rst (async active-low), rng (slave handshake: valid,
// data in / start out), capture pulse, busy, done, word_cnt,
// rd_addr/rd_data synchronous read port (1-cycle latency).
module mt_untemper #(
    parameter int N_WORDS = 624
) (
    input  logic          clk,
    input  logic          rst,
    mt_untemper_if.slave  rng,
    input  logic          capture,
    output logic          busy,
    output logic          done,
    output logic [9:0]    word_cnt,
    input  logic [9:0]    rd_addr,
    output logic [31:0]   rd_data
);

    localparam logic [9:0]  LP_N = 10'(N_WORDS);
    localparam logic [31:0] LP_M7 = 32'h9D2C5680;
    localparam logic [31:0] LP_M15 = 32'hEFC60000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_U18,
        S_U15,
        S_U7,
        S_U11,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_y;
    logic [31:0] r_t;
    logic [1:0]  r_iter;
    logic        r_start;
    logic [9:0]  r_word_cnt;
    logic        w_latch;
    logic        w_we;
    logic        w_last;
    logic [31:0] r_mem [0:N_WORDS-1];

    assign rng.start = r_start;
    assign word_cnt  = r_word_cnt;
    assign w_last    = (r_word_cnt + 10'd1 == LP_N);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: if (capture) w_next = S_WAIT;
            S_WAIT:  if (w_latch) w_next = S_U18;
            S_U18:   w_next = S_U15;
            S_U15:   w_next = S_U7;
            S_U7:    if (r_iter == 2'd3) w_next = S_U11;
            S_U11:   if (r_iter == 2'd1) w_next = S_WRITE;
            S_WRITE: w_next = w_last ? S_DONE : S_WAIT;
            default: w_next = S_IDLE;
        endcase
    end

    // The !r_start guard stops a still-held word from being sampled
    // again in the cycle the generator is dropping valid.
    always_comb begin
        w_latch = (r_state == S_WAIT) && rng.valid && !r_start;
        w_we    = (r_state == S_WRITE);
        done    = (r_state == S_DONE);
        busy    = (r_state != S_IDLE) && (r_state != S_DONE);
    end

    // U7/U11 are fixed-point inversions: each pass fixes another 7
    // (resp. 11) bits, the first pass seeding x from t = y.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_y        <= '0;
            r_t        <= '0;
            r_iter     <= '0;
            r_start    <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_start <= w_latch;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (capture) r_word_cnt <= '0;
                end
                S_WAIT: begin
                    if (w_latch) r_y <= rng.data;
                end
                S_U18: r_y <= r_y ^ (r_y >> 18);
                S_U15: r_y <= r_y ^ ((r_y << 15) & LP_M15);
                S_U7: begin
                    r_iter <= r_iter + 2'd1;
                    if (r_iter == 2'd0) begin
                        r_t <= r_y;
                        r_y <= r_y ^ ((r_y << 7) & LP_M7);
                    end else begin
                        r_y <= r_t ^ ((r_y << 7) & LP_M7);
                    end
                end
                S_U11: begin
                    r_iter <= (r_iter == 2'd1) ? 2'd0 : r_iter + 2'd1;
                    if (r_iter == 2'd0) begin
                        r_t <= r_y;
                        r_y <= r_y ^ (r_y >> 11);
                    end else begin
                        r_y <= r_t ^ (r_y >> 11);
                    end
                end
                S_WRITE: r_word_cnt <= r_word_cnt + 10'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_word_cnt] <= r_y;
    end

    // Read-before-write: a same-address collision returns old data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_addr < LP_N) begin
            rd_data <= r_mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_mt_untemper.sv
// Self-checking bench for mt_untemper: directed vectors, reset,
// held-valid, round-trip and end-to-end MT19937 capture.
module tb_mt_untemper;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        capture = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic        busy;
    logic        done;
    logic [9:0]  word_cnt;
    logic [31:0] rd_data;

    mt_untemper_if rng_if();

    mt_untemper dut (
        .clk      (clk),
        .rst      (rst),
        .rng      (rng_if),
        .capture  (capture),
        .busy     (busy),
        .done     (done),
        .word_cnt (word_cnt),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_start = 0;

    always @(negedge clk) if (rng_if.start === 1'b1) n_start++;

    typedef struct {
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t        vt [3];
    logic [31:0] xs [1000];
    logic [31:0] mt [624];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] temper(input logic [31:0] v);
        logic [31:0] y;
        y = v;
        y = y ^ (y >> 11);
        y = y ^ ((y << 7) & 32'h9D2C5680);
        y = y ^ ((y << 15) & 32'hEFC60000);
        y = y ^ (y >> 18);
        return y;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        capture = 1'b0;
        rng_if.valid = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic pulse_capture();
        capture = 1'b1;
        tick();
        capture = 1'b0;
    endtask

    // Present a word and hold it until the acknowledge is seen.
    task automatic send(input logic [31:0] d, output int edges);
        bit got;
        got = 1'b0;
        edges = 0;
        rng_if.data = d;
        rng_if.valid = 1'b1;
        while (!got && edges < 40) begin
            tick();
            edges++;
            if (rng_if.start === 1'b1) got = 1'b1;
        end
        rng_if.valid = 1'b0;
        if (!got) chk("start_timeout", 32'(got), 32'd1);
    endtask

    task automatic wait_cnt(input logic [9:0] tgt, output int edges);
        edges = 0;
        while (word_cnt !== tgt && edges < 60) begin
            tick();
            edges++;
        end
        chk("word_cnt", 32'(word_cnt), 32'(tgt));
    endtask

    task automatic rd(input logic [9:0] a, output logic [31:0] d);
        rd_addr = a;
        tick();
        d = rd_data;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int pre;
        int last;
        int npulse;
        int g;
        logic [31:0] d;
        logic [31:0] y;

        vt[0] = '{din: 32'h00400091, exp: 32'h00000001};
        vt[1] = '{din: 32'h00000000, exp: 32'h00000000};
        vt[2] = '{din: 32'h88102204, exp: 32'h80000000};

        rng_if.valid = 1'b0;
        rng_if.data = '0;

        // Reset values while reset is held
        #13;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cnt", 32'(word_cnt), 32'd0);
        chk("rst_start", 32'(rng_if.start), 32'd0);
        chk("rst_rd", rd_data, 32'd0);
        tick();
        rst = 1'b1;

        // Reset in the middle of a word (U7)
        pulse_capture();
        send(32'h00400091, e);
        wait_cnt(10'd1, e);
        send(32'h12345678, e);
        tick();
        tick();
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mrst_start", 32'(rng_if.start), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_cnt", 32'(word_cnt), 32'd0);
        chk("mrst_rd", rd_data, 32'd0);
        tick();
        rst = 1'b1;
        pre = n_start;
        rng_if.valid = 1'b1;
        repeat (6) tick();
        chk("idle_no_start", 32'(n_start - pre), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_cnt", 32'(word_cnt), 32'd0);
        rng_if.valid = 1'b0;
        rd(10'd0, d);
        chk("ram_kept", d, 32'h00000001);

        // Directed single-word vectors
        for (int i = 0; i < 3; i++) begin
            do_reset();
            pulse_capture();
            send(vt[i].din, e);
            chk("start_lat", 32'(e), 32'd1);
            tick();
            chk("start_len", 32'(rng_if.start), 32'd0);
            wait_cnt(10'd1, e);
            chk("write_lat", 32'(e + 1), 32'd9);
            rd(10'd0, d);
            chk("vec_rd", d, vt[i].exp);
        end

        // Held valid: one acceptance every 10 cycles, capture ignored
        do_reset();
        pulse_capture();
        rng_if.data = 32'h00400091;
        rng_if.valid = 1'b1;
        last = 0;
        npulse = 0;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (k == 25) capture = 1'b1;
            if (k == 26) capture = 1'b0;
            if (rng_if.start === 1'b1) begin
                if (npulse == 0) chk("held_first", 32'(k), 32'd1);
                else chk("held_gap", 32'(k - last), 32'd10);
                last = k;
                npulse++;
            end
        end
        rng_if.valid = 1'b0;
        chk("held_pulses", 32'(npulse), 32'd5);
        chk("held_cnt", 32'(word_cnt), 32'd4);
        wait_cnt(10'd5, e);

        // Round trip, first full run
        do_reset();
        pulse_capture();
        for (int k = 0; k < 624; k++) begin
            xs[k] = $urandom;
            send(temper(xs[k]), e);
            wait_cnt(10'(k + 1), e);
        end
        chk("rt_done", 32'(done), 32'd1);
        chk("rt_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 624; k++) begin
            rd(10'(k), d);
            chk("rt_word", d, xs[k]);
        end

        // Restart from DONE, collision, capture while busy
        pulse_capture();
        chk("rs_cnt", 32'(word_cnt), 32'd0);
        chk("rs_done", 32'(done), 32'd0);
        chk("rs_busy", 32'(busy), 32'd1);
        xs[624] = $urandom;
        rd_addr = 10'd0;
        send(temper(xs[624]), e);
        wait_cnt(10'd1, e);
        chk("collide_old", rd_data, xs[0]);
        tick();
        chk("collide_new", rd_data, xs[624]);
        for (int k = 1; k < 376; k++) begin
            xs[624 + k] = $urandom;
            send(temper(xs[624 + k]), e);
            wait_cnt(10'(k + 1), e);
            if (k == 10) begin
                pulse_capture();
                chk("busy_cap", 32'(word_cnt), 32'd11);
            end
        end
        for (int k = 0; k < 376; k++) begin
            rd(10'(k), d);
            chk("rt2_word", d, xs[624 + k]);
        end

        // End to end against an MT19937 model, seed 5489
        mt[0] = 32'd5489;
        for (int i = 1; i < 624; i++)
            mt[i] = 32'd1812433253 * (mt[i-1] ^ (mt[i-1] >> 30)) + 32'(i);
        for (int i = 0; i < 624; i++) begin
            y = (mt[i] & 32'h80000000) | (mt[(i+1)%624] & 32'h7fffffff);
            mt[i] = mt[(i+397)%624] ^ (y >> 1) ^ (y[0] ? 32'h9908b0df : 32'h0);
        end
        do_reset();
        pulse_capture();
        pre = n_start;
        for (int i = 0; i < 624; i++) send(temper(mt[i]), e);
        g = 0;
        while (done !== 1'b1 && g < 100) begin
            tick();
            g++;
        end
        chk("e2e_done", 32'(done), 32'd1);
        chk("e2e_cnt", 32'(word_cnt), 32'd624);
        chk("e2e_starts", 32'(n_start - pre), 32'd624);
        for (int i = 0; i < 624; i++) begin
            rd(10'(i), d);
            if (i == 0) chk("e2e_first", temper(d), 32'd3499211612);
            chk("e2e_mt", d, mt[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mt_untemper.md
# mt_untemper

Capture-side companion to the MT19937 generator. It consumes tempered 32-bit words over the generator's `start`/`valid` handshake and applies the inverse tempering transform to each word, recovering the generator's internal state. It stores the 624 recovered state words in a block RAM with a synchronous read port. It is used for verification and for state cloning/prediction downstream of the `rng` block.

## Interface
Parameters:
- `N_WORDS`, 624: words captured per run; fixed to the MT19937 state size, not intended to be overridden.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `capture`  in  1  one-cycle pulse that starts a capture run of `N_WORDS` words.
- `rng_valid`  in  1  generator word-valid (level, held until acknowledged).
- `rng_data`  in  32  tempered generator output.
- `rng_start`  out  1  registered one-cycle acknowledge/request pulse to the generator.
- `busy`  out  1  high from accepting `capture` until the last state word is written.
- `done`  out  1  high after a complete run; cleared by the next accepted `capture`.
- `word_cnt`  out  10  number of state words written in the current run (0..624).
- `rd_addr`  in  10  state RAM read address (0..623).
- `rd_data`  out  32  state word at `rd_addr`; registered, 1-cycle latency.

## Operation
- FSM states: IDLE, WAIT, U18, U15, U7, U11, WRITE, DONE.
- IDLE/DONE + `capture`=1 -> WAIT: `word_cnt`<=0, `busy`<=1, `done`<=0. `capture` is ignored in every other state.
- WAIT: if `rng_valid`=1 and `rng_start`=0, latch `rng_data` into working register y, then go to U18. The `rng_start` guard prevents the same held word from being sampled twice.
- U18: y ^= y>>18 (exact in one step).
- U15: y ^= (y<<15) & 0xEFC60000 (exact in one step).
- U7: latch t<=y, then iterate x = t ^ ((x<<7) & 0x9D2C5680) 4 times, starting from x = t. An internal 2-bit iteration counter is used; 4 cycles total.
- U11: latch t<=y, then iterate x = t ^ (x>>11) 2 times, starting from x = t. 2 cycles total.
- WRITE: mt_ram[`word_cnt`]<=x, `word_cnt`<=`word_cnt`+1. If the new count is 624 -> DONE (`busy`<=0, `done`<=1); else -> WAIT.
- All arithmetic is 32-bit. Shifts are logical and zero-filled. No carries are involved.
- `rng_start`: asserted for exactly one cycle, in the cycle after a word is latched in WAIT. Every accepted word, including the 624th, is acknowledged.
- Read port: `rd_data`<=mt_ram[`rd_addr`] every cycle, independent of FSM state.
  - If a read and a write hit the same address in the same cycle, the read returns the old data.
  - Out-of-range `rd_addr` (624..1023) returns an undefined value.
- Reset (asynchronous, any state, including mid-word):
  - FSM returns to IDLE.
  - `rng_start`=0, `busy`=0, `done`=0, `word_cnt`=0, `rd_data`=0.
  - RAM contents are not cleared.
  - A partially processed word is discarded.

## Timing
- Word latency: latch at cycle T; U18 at T+1; U15 at T+2; U7 at T+3..T+6; U11 at T+7..T+8; RAM write at T+9.
- `rng_start` is high during cycle T+1.
- Earliest next latch is T+10, so the block sustains 1 word per 10 cycles. The generator produces 1 word per 4 cycles after its twist, so the generator side waits.
- `word_cnt` updates at the end of WRITE. `busy` falls and `done` rises on the same edge as the 624th write.
- `rd_data` is valid 1 cycle after `rd_addr` is applied.
- The generator deasserts `valid` on the edge after `start` is seen, so no word is lost or duplicated.

## Test plan
- Reset values: assert `rst`=0 mid-run (in U7). Required: all outputs at their reset values immediately; FSM in IDLE after release; `rng_start` stays 0 until a new `capture`.
- Single-word vectors, using a bench-driven `rng_valid`:
  - `rng_data`=0x00400091 -> `rd_data`@0 = 0x00000001.
  - `rng_data`=0x00000000 -> `rd_data`@0 = 0x00000000.
  - In both cases `rng_start` pulses exactly at T+1.
- Round-trip: 1000 random x, with the bench applying the reference temper(x). Required: each stored word equals x, and `word_cnt` increments once per word.
- Held valid: keep `rng_valid` high continuously. Required: words are accepted every 10 cycles; each acceptance is followed by exactly one `rng_start` pulse; no double sample.
- End-to-end with `rng` (SEED=5489): pulse `capture`. Required:
  - the first captured tempered word is 3499211612;
  - after `done` rises, `word_cnt`=624 and mt_ram[i] equals the generator's internal mt[i] for all i after its first twist;
  - 624 `rng_start` pulses in total.
- Control corners:
  - `capture` while `busy` is ignored (`word_cnt` is not cleared).
  - `capture` while in DONE restarts the run at 0.
  - Read/write collision on the same address returns the old word.
